// File: rtl/sad_pkg.sv
// Shared constants and helpers for the SAD engine datapath.
// The optional SAD_MIN_TRACK_EN feature in sad_datapath uses BLK_IDX_W.
package sad_pkg;

  localparam int PIX_W_DEF = 8;
  localparam int N_PIX_DEF = 256;
  localparam int BLK_IDX_W = 16;

  // Ceiling log2 over a bounded loop so it stays usable as a constant function.
  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) res = i + 1;
    end
    return res;
  endfunction

  localparam int ADDR_W_DEF = clog2(N_PIX_DEF);
  localparam int SUM_W_DEF  = PIX_W_DEF + ADDR_W_DEF;

endpackage

// File: rtl/sad_absdiff.sv
// Combinational unsigned absolute difference of two pixels.
module sad_absdiff
  import sad_pkg::*;
#(
  parameter int W = PIX_W_DEF
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff
);

  // Subtracting the smaller operand from the larger one never underflows.
  assign diff = (a >= b) ? (a - b) : (b - a);

endmodule

// File: rtl/sad_datapath.sv
// SAD datapath: read-address counter, |A-B| accumulator and result register
// driven by the SAD control FSM strobes. Define SAD_MIN_TRACK_EN to add
// running minimum-SAD tracking across blocks.
module sad_datapath
  import sad_pkg::*;
#(
  parameter  int N_PIX  = N_PIX_DEF,
  parameter  int PIX_W  = PIX_W_DEF,
  localparam int ADDR_W = clog2(N_PIX),
  localparam int SUM_W  = PIX_W + ADDR_W
) (
  input  logic                 clk,
  input  logic                 Mrst_n,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 en_reg,
  input  logic [PIX_W-1:0]     a_data,
  input  logic [PIX_W-1:0]     b_data,
  output logic [ADDR_W-1:0]    addr,
  output logic                 comp,
  output logic [SUM_W-1:0]     sad,
  output logic                 sad_valid
`ifdef SAD_MIN_TRACK_EN
  ,
  output logic [SUM_W-1:0]     sad_min,
  output logic [BLK_IDX_W-1:0] blk_idx,
  output logic [BLK_IDX_W-1:0] min_idx,
  output logic                 min_upd
`endif
);

  localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W + 1)'(N_PIX);
  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W + 1)'(1);

  // One extra counter bit lets cnt park at N_PIX instead of wrapping addr to 0.
  logic [ADDR_W:0]  cnt;
  logic [SUM_W-1:0] acc;
  logic [SUM_W-1:0] sad_r;
  logic             vld;
  logic [PIX_W-1:0] diff;
  logic [SUM_W-1:0] diff_ext;

  sad_absdiff #(.W(PIX_W)) u_absdiff (
    .a    (a_data),
    .b    (b_data),
    .diff (diff)
  );

  assign diff_ext  = {{(SUM_W - PIX_W){1'b0}}, diff};
  assign addr      = cnt[ADDR_W-1:0];
  assign comp      = (cnt == CNT_FULL);
  assign sad       = sad_r;
  assign sad_valid = vld;

  // Counter and accumulator: FSM clear wins over accumulate; saturate at comp.
  always_ff @(posedge clk or negedge Mrst_n) begin
    if (!Mrst_n) begin
      cnt <= '0;
      acc <= '0;
    end else if (rst) begin
      cnt <= '0;
      acc <= '0;
    end else if (en && !comp) begin
      acc <= acc + diff_ext;
      cnt <= cnt + CNT_ONE;
    end
  end

  // NOTE: non-blocking assignments make sad_r sample acc as it was before this
  // edge, so an en_reg coinciding with en captures the pre-update sum.
  always_ff @(posedge clk or negedge Mrst_n) begin
    if (!Mrst_n) begin
      sad_r <= '0;
      vld   <= 1'b0;
    end else begin
      if (en_reg) sad_r <= acc;
      if (rst)         vld <= 1'b0;
      else if (en_reg) vld <= 1'b1;
    end
  end

`ifdef SAD_MIN_TRACK_EN
  localparam logic [BLK_IDX_W-1:0] IDX_ONE = BLK_IDX_W'(1);

  // Minimum tracking survives FSM rst; only the master reset clears it.
  always_ff @(posedge clk or negedge Mrst_n) begin
    if (!Mrst_n) begin
      sad_min <= '1;
      blk_idx <= '0;
      min_idx <= '0;
      min_upd <= 1'b0;
    end else begin
      min_upd <= 1'b0;
      if (en_reg) begin
        blk_idx <= blk_idx + IDX_ONE;
        if (acc < sad_min) begin
          sad_min <= acc;
          min_idx <= blk_idx;
          min_upd <= 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_sad_datapath.sv
// Scoreboard bench for sad_datapath (N_PIX=4, PIX_W=8) with a reference FSM
// driving the rst/en/en_reg strobes. Define SAD_MIN_TRACK_EN to cover min tracking.
module tb_sad_datapath;

  localparam int N   = 4;
  localparam int PW  = 8;
  localparam int AW  = 2;
  localparam int SW  = 10;
  localparam int LAT = 2 * N + 3;

  logic          clk = 1'b0;
  logic          Mrst_n;
  logic          rst, en, en_reg;
  logic [PW-1:0] a_data, b_data;
  logic [AW-1:0] addr;
  logic          comp;
  logic [SW-1:0] sad;
  logic          sad_valid;
`ifdef SAD_MIN_TRACK_EN
  logic [SW-1:0] sad_min;
  logic [15:0]   blk_idx, min_idx;
  logic          min_upd;
`endif

  logic [PW-1:0] mem_a [N];
  logic [PW-1:0] mem_b [N];
  logic [SW-1:0] exp_q [$];
  logic [SW-1:0] exp_v;
  logic          prev_valid = 1'b0;
  logic          upd_seen = 1'b0;
  int            tests = 0;
  int            fails = 0;
  int            lat;

  sad_datapath #(.N_PIX(N), .PIX_W(PW)) dut (
    .clk       (clk),
    .Mrst_n    (Mrst_n),
    .rst       (rst),
    .en        (en),
    .en_reg    (en_reg),
    .a_data    (a_data),
    .b_data    (b_data),
    .addr      (addr),
    .comp      (comp),
    .sad       (sad),
    .sad_valid (sad_valid)
`ifdef SAD_MIN_TRACK_EN
    ,
    .sad_min   (sad_min),
    .blk_idx   (blk_idx),
    .min_idx   (min_idx),
    .min_upd   (min_upd)
`endif
  );

  always #5 clk = ~clk;

  assign a_data = mem_a[addr];
  assign b_data = mem_b[addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every rising edge of sad_valid consumes one expected SAD.
  always @(negedge clk) begin
    if (sad_valid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sad_unexpected: got %0d with no result expected", sad);
      end else begin
        exp_v = exp_q.pop_front();
        check("sad_result", 32'(sad), 32'(exp_v));
      end
    end
    prev_valid <= sad_valid;
  end

  task automatic load(input logic [N-1:0][PW-1:0] a, input logic [N-1:0][PW-1:0] b);
    for (int i = 0; i < N; i++) begin
      mem_a[i] = a[i];
      mem_b[i] = b[i];
    end
  endtask

  // Reference FSM: go at edge 0, S1 rst, S2 poll comp / S3 en per pixel, S4 en_reg.
  task automatic run_block(input bit chk_addr, output int latency);
    int  edges;
    int  pix;
    bit  done;
    edges = 0;
    pix = 0;
    done = 1'b0;
    latency = -1;
    @(negedge clk); rst = 1'b0; en = 1'b0; en_reg = 1'b0;
    @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); edges = 1;
    @(negedge clk); rst = 1'b0;
    while (!done && edges < 4 * N + 8) begin
      if (comp) begin
        @(posedge clk); edges++;
        @(negedge clk); en_reg = 1'b1;
        @(posedge clk); edges++;
        @(negedge clk); en_reg = 1'b0;
        done = 1'b1;
        latency = edges;
`ifdef SAD_MIN_TRACK_EN
        upd_seen = min_upd;
`endif
      end else begin
        @(posedge clk); edges++;
        @(negedge clk);
        if (chk_addr) check("addr_step", 32'(addr), 32'(pix));
        en = 1'b1;
        @(posedge clk); edges++;
        @(negedge clk); en = 1'b0;
        pix++;
      end
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL block_timeout: comp not seen within %0d edges", edges);
    end
  endtask

  task automatic pulse(input bit p_rst, input bit p_en, input bit p_en_reg);
    @(negedge clk);
    rst = p_rst; en = p_en; en_reg = p_en_reg;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; en = 1'b0; en_reg = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Mrst_n = 1'b0;
    rst = 1'b0; en = 1'b0; en_reg = 1'b0;
    load('0, '0);
    #12;
    check("rst_addr", 32'(addr), 0);
    check("rst_comp", 32'(comp), 0);
    check("rst_sad", 32'(sad), 0);
    check("rst_valid", 32'(sad_valid), 0);
    Mrst_n = 1'b1;

    // Nominal block: |10-12|+|20-15|+|30-30|+|40-50| = 17
    load({8'd40, 8'd30, 8'd20, 8'd10}, {8'd50, 8'd30, 8'd15, 8'd12});
    exp_q.push_back(10'd17);
    run_block(1'b1, lat);
    check("valid_latency", 32'(lat), 32'(LAT));
    check("comp_after_block", 32'(comp), 1);
    check("valid_after_block", 32'(sad_valid), 1);

    // Overrun guard: extra en pulses leave everything parked.
    @(negedge clk); en = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); en = 1'b0;
    check("ovr_cnt", 32'(dut.cnt), 4);
    check("ovr_addr", 32'(addr), 0);
    check("ovr_acc", 32'(dut.acc), 17);
    check("ovr_comp", 32'(comp), 1);
    pulse(1'b0, 1'b0, 1'b1);
    check("ovr_sad", 32'(sad), 17);

    // Max magnitude, both operand orders.
    load({4{8'd255}}, {4{8'd0}});
    exp_q.push_back(10'd1020);
    run_block(1'b0, lat);
    load({4{8'd0}}, {4{8'd255}});
    exp_q.push_back(10'd1020);
    run_block(1'b0, lat);

    // rst together with en: clear wins.
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    check("acc_one_pix", 32'(dut.acc), 255);
    pulse(1'b1, 1'b1, 1'b0);
    check("rst_en_acc", 32'(dut.acc), 0);
    check("rst_en_cnt", 32'(dut.cnt), 0);

    // en_reg together with rst: capture still happens, valid ends low.
    pulse(1'b0, 1'b1, 1'b0);
    pulse(1'b1, 1'b0, 1'b1);
    check("rst_enreg_sad", 32'(sad), 255);
    check("rst_enreg_valid", 32'(sad_valid), 0);

    // en_reg together with en: pre-update acc captured.
    load({8'd0, 8'd0, 8'd3, 8'd5}, {4{8'd0}});
    pulse(1'b0, 1'b1, 1'b0);
    exp_q.push_back(10'd5);
    pulse(1'b0, 1'b1, 1'b1);
    check("en_enreg_sad", 32'(sad), 5);
    check("en_enreg_acc", 32'(dut.acc), 8);

    // Async reset mid-block, between edges.
    load({8'd40, 8'd30, 8'd20, 8'd10}, {8'd50, 8'd30, 8'd15, 8'd12});
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    check("mid_addr", 32'(addr), 2);
    #2 Mrst_n = 1'b0;
    #1;
    check("async_addr", 32'(addr), 0);
    check("async_comp", 32'(comp), 0);
    check("async_sad", 32'(sad), 0);
    check("async_valid", 32'(sad_valid), 0);
    #1 Mrst_n = 1'b1;
    exp_q.push_back(10'd17);
    run_block(1'b0, lat);

`ifdef SAD_MIN_TRACK_EN
    @(negedge clk); #2 Mrst_n = 1'b0;
    #1;
    check("min_rst_sad_min", 32'(sad_min), 1023);
    check("min_rst_blk_idx", 32'(blk_idx), 0);
    #1 Mrst_n = 1'b1;
    exp_q.push_back(10'd17);
    run_block(1'b0, lat);
    check("min_upd_blk0", 32'(upd_seen), 1);
    check("sad_min_blk0", 32'(sad_min), 17);
    check("min_idx_blk0", 32'(min_idx), 0);
    @(negedge clk);
    check("min_upd_pulse_end", 32'(min_upd), 0);
    load({8'd40, 8'd30, 8'd20, 8'd10}, {8'd31, 8'd30, 8'd20, 8'd10});
    exp_q.push_back(10'd9);
    run_block(1'b0, lat);
    check("min_upd_blk1", 32'(upd_seen), 1);
    exp_q.push_back(10'd9);
    run_block(1'b0, lat);
    check("min_upd_blk2_tie", 32'(upd_seen), 0);
    check("final_sad_min", 32'(sad_min), 9);
    check("final_min_idx", 32'(min_idx), 1);
    check("final_blk_idx", 32'(blk_idx), 3);
`endif

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
